demux4_stream: RTL and testbench



---
 rtl/demux4_stream.sv | 71 +++++++
 tb/tb_demux4_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-entry slot per channel.
// Define DEMUX4_CNT_EN to add per-channel delivered-beat counters on out_count.
module demux4_stream #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready
`ifdef DEMUX4_CNT_EN
    ,
    output logic [4*16-1:0]         out_count
`endif
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 16;

    logic           accept_c;
    logic [NCH-1:0] wr_en_c;
    logic [NCH-1:0] drain_c;

    // Ready depends only on the selected slot, never on in_valid.
    always_comb begin
        in_ready = !out_valid[in_sel] | out_ready[in_sel];
        accept_c = in_valid & in_ready;
        wr_en_c  = '0;
        if (accept_c) begin
            wr_en_c[in_sel] = 1'b1;
        end
        drain_c  = out_valid & out_ready;
    end

    // Slot update: a write wins over a drain so a simultaneous reload leaves no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_en_c[k]) begin
                    out_valid[k]                         <= 1'b1;
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                end else if (drain_c[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX4_CNT_EN
    // Delivered-beat counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (drain_c[k]) begin
                    out_count[k*CNT_W +: CNT_W] <= out_count[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: queue-per-channel reference model checked every cycle, plus directed literal checks.
module tb_demux4_stream;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
`ifdef DEMUX4_CNT_EN
    logic [63:0]  out_count;
`endif

    demux4_stream #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX4_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a FIFO of capacity one; delivered[] counts pops.
    logic [31:0] q [4][$];
    int          delivered [4];
    logic [3:0]  pend_drain;
    logic        pend_acc;
    logic [1:0]  pend_sel;
    logic [31:0] pend_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                delivered[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pend_drain[k]) begin
                    void'(q[k].pop_front());
                    delivered[k] = delivered[k] + 1;
                end
            end
            if (pend_acc) q[pend_sel].push_back(pend_data);
        end
    end

    // Compare process: check outputs against the model, then plan the next edge.
    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = (q[in_sel].size() == 0) || out_ready[in_sel];
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
                if (q[k].size() != 0)
                    chk($sformatf("out_data[%0d]", k), 64'(out_data[k*32 +: 32]), 64'(q[k][0]));
`ifdef DEMUX4_CNT_EN
                chk($sformatf("out_count[%0d]", k), 64'(out_count[k*16 +: 16]), 64'(16'(delivered[k])));
`endif
            end
        end
        for (int k = 0; k < 4; k++) pend_drain[k] = (q[k].size() != 0) && out_ready[k];
        pend_acc  = in_valid && exp_ready;
        pend_sel  = in_sel;
        pend_data = in_data;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [1:0] s, input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=in_ready0 expected=accept sel=%0d", s);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sel   = 2'($urandom);
        in_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hDEADBEEF;
        out_ready = 4'b0000;
        pend_drain = '0;
        pend_acc  = 1'b0;
        pend_sel  = '0;
        pend_data = '0;

        // Reset state while a request is already pending
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(4'b0000));
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data[63:0] | out_data[127:64]), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_valid", 64'(out_valid), 64'(4'b0100));
        chk("first_data_c", 64'(out_data[64 +: 32]), 64'h0000_0000_DEAD_BEEF);

        // Back-to-back across all channels with every consumer ready
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            send(2'(i % 4), 32'(i + 1));
            chk($sformatf("b2b_valid_%0d", i), 64'(out_valid[i % 4]), 64'd1);
            chk($sformatf("b2b_data_%0d", i), 64'(out_data[(i % 4)*32 +: 32]), 64'(i + 1));
        end
        idle(2);
        chk("b2b_empty", 64'(out_valid), 64'(4'b0000));

        // Stall on channel b, then release with a same-cycle reload
        out_ready = 4'b1101;
        send(2'd1, 32'h11);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_hold_b", 64'(out_data[32 +: 32]), 64'h11);
            chk("stall_valid_b", 64'(out_valid[1]), 64'd1);
        end
        @(posedge clk);
        #1 out_ready[1] = 1'b0;
        #1 out_ready[1] = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("reload_valid_b", 64'(out_valid[1]), 64'd1);
        chk("reload_data_b", 64'(out_data[32 +: 32]), 64'h22);
        idle(1);
        chk("drained_b", 64'(out_valid[1]), 64'd0);

        // Independence: d stalled full while a takes a beat
        out_ready = 4'b0000;
        send(2'd3, 32'h33);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'hA5;
        @(negedge clk);
        chk("indep_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("indep_a", 64'(out_data[31:0]), 64'hA5);
        chk("indep_d_valid", 64'(out_valid[3]), 64'd1);
        chk("indep_d_data", 64'(out_data[96 +: 32]), 64'h33);
        out_ready = 4'b1001;
        idle(2);

        // Reset mid-stream with channels a and c full
        out_ready = 4'b0000;
        send(2'd0, 32'hC0FFEE00);
        send(2'd2, 32'hC0FFEE02);
        chk("pre_rst_valid", 64'(out_valid), 64'(4'b0101));
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(4'b0000));
        idle(2);
        rst_n = 1'b1;
        out_ready = 4'b1111;
        idle(3);
        chk("post_rst_empty", 64'(out_valid), 64'(4'b0000));

`ifdef DEMUX4_CNT_EN
        // Counter wrap on channel b
        for (int i = 0; i < 65537; i++) send(2'd1, 32'(i));
        idle(2);
        chk("cnt_b_wrap", 64'(out_count[16 +: 16]), 64'd1);
        chk("cnt_others", 64'({out_count[63:32], out_count[15:0]}), 64'd0);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
